// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: sequencer states,
// special-register indices and the fixed preset values.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_e;

  localparam int DL_IDX    = 27;
  localparam int SP_IDX    = 28;
  localparam int GP_IDX    = 29;
  localparam int AP_IDX    = 30;
  localparam int RTRUE_IDX = 31;

  localparam int DL_INIT    = 0;
  localparam int AP_INIT    = 0;
  localparam int RTRUE_INIT = 1;

  localparam int PRESET_CNT = 5;
  localparam int IDX_W      = 3;

endpackage

// File: rtl/regfile_preset_rom.sv
// Combinational lookup from preset sequence index to the special register
// address and its power-on value.
module regfile_preset_rom
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_INIT = 48,
  parameter int GP_INIT = 49
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // NOTE: every output gets a default before the case so no latch is inferred
  // for index values outside the table.
  always_comb begin
    addr = '0;
    data = '0;
    case (idx)
      3'd0: begin addr = ADDR_W'(DL_IDX);    data = DATA_W'(DL_INIT);    end
      3'd1: begin addr = ADDR_W'(SP_IDX);    data = DATA_W'(SP_INIT);    end
      3'd2: begin addr = ADDR_W'(GP_IDX);    data = DATA_W'(GP_INIT);    end
      3'd3: begin addr = ADDR_W'(AP_IDX);    data = DATA_W'(AP_INIT);    end
      3'd4: begin addr = ADDR_W'(RTRUE_IDX); data = DATA_W'(RTRUE_INIT); end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port: writes the special-register presets
// after reset, then arbitrates between core writeback and the I/O unit.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int SP_INIT  = 48,
  parameter int GP_INIT  = 49
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              io_valid,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              init_done
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PRESET_CNT - 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              io_win;
  logic              wb_win;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  regfile_preset_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SP_INIT(SP_INIT),
    .GP_INIT(GP_INIT)
  ) u_preset_rom (
    .idx (idx),
    .addr(rom_addr),
    .data(rom_data)
  );

  // Handshakes are masked while reset is held so neither requester believes
  // it was accepted by a write that the reset is about to discard.
  always_comb begin
    io_win   = 1'b0;
    wb_win   = 1'b0;
    wb_stall = wb_valid;
    io_ready = 1'b0;
    if (!reset) begin
      wb_stall = 1'b1;
    end else if (state == RUN) begin
      io_win   = io_valid && (!wb_valid || wait_cnt == WAIT_MAX);
      wb_win   = wb_valid && !io_win;
      wb_stall = wb_valid && !wb_win;
      io_ready = io_win;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      idx       <= '0;
      wait_cnt  <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      rf_we    <= 1'b1;
      rf_addr  <= rom_addr;
      rf_data  <= rom_data;
      wait_cnt <= '0;
      if (idx == LAST_IDX) begin
        state     <= RUN;
        init_done <= 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      rf_we <= io_win || wb_win;
      if (io_win) begin
        rf_addr <= io_addr;
        rf_data <= io_data;
      end else if (wb_win) begin
        rf_addr <= wb_addr;
        rf_data <= wb_data;
      end
      // Counts consecutive denials only; any break in the request restarts it.
      if (io_valid && !io_win) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: preset sequence, arbitration,
// I/O starvation bound, resets in INIT and RUN, and the MAX_WAIT=0 variant.
module tb_regfile_write_arbiter;

  typedef struct {
    string       name;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        iov;
    logic [4:0]  ioa;
    logic [31:0] iod;
    logic        stall;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, io_valid;
  logic [4:0]  wb_addr, io_addr;
  logic [31:0] wb_data, io_data;
  logic        wb_stall, io_ready, rf_we, init_done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        d0_wb_stall, d0_io_ready, d0_rf_we, d0_init_done;
  logic [4:0]  d0_rf_addr;
  logic [31:0] d0_rf_data;

  int   checks = 0;
  int   errors = 0;
  wr_t  sb_q[$];
  vec_t preset_tab[5];
  vec_t run_tab[11];
  vec_t idle_vec;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data), .io_ready(io_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .init_done(init_done)
  );

  regfile_write_arbiter #(.MAX_WAIT(0)) dut0 (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(d0_wb_stall),
    .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data), .io_ready(d0_io_ready),
    .rf_we(d0_rf_we), .rf_addr(d0_rf_addr), .rf_data(d0_rf_data), .init_done(d0_init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic wbv, input logic [4:0] wba,
                              input logic [31:0] wbd, input logic iov, input logic [4:0] ioa,
                              input logic [31:0] iod, input logic st, input logic rd,
                              input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic dn);
    vec_t v;
    v.name = n; v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.iov = iov; v.ioa = ioa; v.iod = iod;
    v.stall = st; v.rdy = rd; v.we = we; v.addr = a; v.data = d; v.done = dn;
    return v;
  endfunction

  // Drives one vector, checks the combinational handshake mid-cycle and the
  // registered write just after the following edge via the scoreboard.
  task automatic apply(input vec_t v);
    wr_t e;
    wb_valid = v.wbv; wb_addr = v.wba; wb_data = v.wbd;
    io_valid = v.iov; io_addr = v.ioa; io_data = v.iod;
    @(negedge clock);
    check({v.name, " wb_stall"}, 32'(wb_stall), 32'(v.stall));
    check({v.name, " io_ready"}, 32'(io_ready), 32'(v.rdy));
    sb_q.push_back('{we: v.we, addr: v.addr, data: v.data, done: v.done});
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", v.name);
    end else begin
      e = sb_q.pop_front();
      check({v.name, " rf_we"}, 32'(rf_we), 32'(e.we));
      check({v.name, " rf_addr"}, 32'(rf_addr), 32'(e.addr));
      check({v.name, " rf_data"}, rf_data, e.data);
      check({v.name, " init_done"}, 32'(init_done), 32'(e.done));
    end
  endtask

  // Asserts reset just after an edge, checks the asynchronous reset state,
  // and releases it one cycle later just after the next edge.
  task automatic do_reset(input string n);
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    io_valid = 1'b1; io_addr = 5'd9; io_data = 32'h9999_0009;
    reset = 1'b0;
    #1;
    check({n, " rf_we"}, 32'(rf_we), 32'd0);
    check({n, " rf_addr"}, 32'(rf_addr), 32'd0);
    check({n, " rf_data"}, rf_data, 32'd0);
    check({n, " init_done"}, 32'(init_done), 32'd0);
    check({n, " wb_stall"}, 32'(wb_stall), 32'd1);
    check({n, " io_ready"}, 32'(io_ready), 32'd0);
    @(posedge clock);
    #1;
    io_valid = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    io_valid = 1'b0; io_addr = '0; io_data = '0;

    preset_tab[0] = mk("preset0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 27, 0,  0);
    preset_tab[1] = mk("preset1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 28, 48, 0);
    preset_tab[2] = mk("preset2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 29, 49, 0);
    preset_tab[3] = mk("preset3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 0,  0);
    preset_tab[4] = mk("preset4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1,  1);
    idle_vec      = mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 1,  1);

    run_tab[0]  = mk("io_only",  0, 0,  0,     1, 5, 32'hDEADBEEF, 0, 0, 1, 5,  32'hDEADBEEF, 1);
    run_tab[0].rdy = 1'b1;
    run_tab[1]  = mk("deny1",    1, 10, 32'hA0, 1, 7, 32'hCAFE0007, 0, 0, 1, 10, 32'hA0, 1);
    run_tab[2]  = mk("deny2",    1, 11, 32'hA1, 1, 7, 32'hCAFE0007, 0, 0, 1, 11, 32'hA1, 1);
    run_tab[3]  = mk("deny3",    1, 12, 32'hA2, 1, 7, 32'hCAFE0007, 0, 0, 1, 12, 32'hA2, 1);
    run_tab[4]  = mk("deny4_sp", 1, 28, 32'hA3, 1, 7, 32'hCAFE0007, 0, 0, 1, 28, 32'hA3, 1);
    run_tab[5]  = mk("io_force", 1, 13, 32'hA4, 1, 7, 32'hCAFE0007, 1, 1, 1, 7,  32'hCAFE0007, 1);
    run_tab[6]  = mk("wb_resume",1, 13, 32'hA4, 1, 8, 32'hBEEF0008, 0, 0, 1, 13, 32'hA4, 1);
    run_tab[7]  = mk("no_req",   0, 0,  0,     0, 0, 0,            0, 0, 0, 13, 32'hA4, 1);
    run_tab[8]  = mk("wb_r0",    1, 0,  32'hA5, 1, 8, 32'hBEEF0008, 0, 0, 1, 0,  32'hA5, 1);
    run_tab[9]  = mk("io_alone", 0, 0,  0,     1, 8, 32'hBEEF0008, 0, 1, 1, 8,  32'hBEEF0008, 1);
    run_tab[10] = mk("wb_alone", 1, 14, 32'hA6, 0, 0, 0,            0, 0, 1, 14, 32'hA6, 1);

    @(posedge clock);
    #1;
    do_reset("reset0");
    foreach (preset_tab[i]) apply(preset_tab[i]);
    apply(idle_vec);

    // Writeback requesting throughout INIT is held off until RUN.
    do_reset("reset1");
    for (int i = 0; i < 5; i++) begin
      v = preset_tab[i];
      v.name = {"wb_in_init", v.name};
      v.wbv = 1'b1; v.wba = 5'd3; v.wbd = 32'h1234; v.stall = 1'b1;
      apply(v);
    end
    apply(mk("first_run", 1, 3, 32'h1234, 0, 0, 0, 0, 0, 1, 3, 32'h1234, 1));

    foreach (run_tab[i]) apply(run_tab[i]);

    // rf_we is high from wb_alone; reset in RUN must drop it at once.
    do_reset("run_reset");
    apply(preset_tab[0]);
    apply(preset_tab[1]);
    do_reset("init_reset");
    foreach (preset_tab[i]) apply(preset_tab[i]);
    apply(idle_vec);

    // MAX_WAIT=0 instance: I/O wins every cycle it is requesting.
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h20;
      io_valid = 1'b1; io_addr = 5'd21; io_data = 32'h21 + 32'(i);
      @(negedge clock);
      check("mw0 io_ready", 32'(d0_io_ready), 32'd1);
      check("mw0 wb_stall", 32'(d0_wb_stall), 32'd1);
      @(posedge clock);
      #1;
      check("mw0 rf_we", 32'(d0_rf_we), 32'd1);
      check("mw0 rf_addr", 32'(d0_rf_addr), 32'd21);
      check("mw0 rf_data", d0_rf_data, 32'h21 + 32'(i));
    end
    io_valid = 1'b0;
    @(negedge clock);
    check("mw0 wb_only stall", 32'(d0_wb_stall), 32'd0);
    @(posedge clock);
    #1;
    check("mw0 wb_only addr", 32'(d0_rf_addr), 32'd20);
    check("mw0 wb_only data", d0_rf_data, 32'h20);
    check("mw0 init_done", 32'(d0_init_done), 32'd1);
    wb_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, a sequencer writes the fixed special-register presets: $dl=r27, $sp=r28, $gp=r29, $ap=r30, $RTRUE=r31.
- It then shares the write port between the core writeback path and the I/O unit.
- Sits between writeback/I-O logic and the register file inputs write_reg/data/controleEscrita, replacing the register file's internal first-write preset flag.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- MAX_WAIT, 4, cycles an I/O request may be denied before it overrides writeback; 0 = I/O always wins.
- SP_INIT, 48, preset value for r28 ($sp).
- GP_INIT, 49, preset value for r29 ($gp).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  core writeback request.
- wb_addr  in  ADDR_W  writeback destination register.
- wb_data  in  DATA_W  writeback value.
- wb_stall  out  1  combinational; core must hold its request this cycle.
- io_valid  in  1  I/O unit write request.
- io_addr  in  ADDR_W  I/O destination register.
- io_data  in  DATA_W  I/O write value.
- io_ready  out  1  combinational; high = I/O request accepted this cycle.
- rf_we  out  1  registered; drives controleEscrita.
- rf_addr  out  ADDR_W  registered; drives write_reg.
- rf_data  out  DATA_W  registered; drives data.
- init_done  out  1  registered; presets complete.

Behaviour:
- Reset asserted (async): state=INIT, idx=0, wait_cnt=0, rf_we=0, rf_addr=0, rf_data=0, init_done=0. While reset is low, wb_stall=1 and io_ready=0.
- INIT state, one preset per clock, idx 0..4:
  - Each edge registers rf_we=1, rf_addr=27+idx, rf_data from the table: 0, SP_INIT, GP_INIT, 0, 1.
  - The edge that issues idx=4 also sets state=RUN and init_done=1.
  - So rf_we is high for exactly 5 consecutive cycles after reset release.
  - In INIT: wb_stall=wb_valid, io_ready=0, wait_cnt held at 0.
- RUN state, evaluated each cycle:
  - io_win = io_valid && (!wb_valid || wait_cnt==MAX_WAIT).
  - wb_win = wb_valid && !io_win.
  - wb_stall = wb_valid && !wb_win.
  - io_ready = io_win.
- Write latency is 1 cycle: the winner's addr/data are registered onto rf_addr/rf_data with rf_we=1 on the next edge.
- No winner: rf_we=0, and rf_addr/rf_data hold their previous values.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when io_valid && !io_win.
  - Clears to 0 when io_win or !io_valid.
- Requesters hold valid/addr/data stable until wb_stall is low or io_ready is high. A requester that drops valid before acceptance simply withdraws; there is no error.
- Both requesters valid with wait_cnt<MAX_WAIT: writeback wins and I/O waits.
- After MAX_WAIT consecutive denials, I/O wins exactly once, then wait_cnt clears. This bounds I/O latency to MAX_WAIT+1 cycles.
- Same-address conflicts: only one write per cycle, so there is no ordering hazard inside the block. The last granted write lands last.
- Writes to r27..r31 after INIT are permitted and overwrite the presets. r0 is not special.
- Reset mid-INIT restarts the preset sequence from idx=0.
- Reset in RUN drops any registered write: rf_we falls asynchronously, and the unaccepted request is not retried by this block.
- State stays RUN until reset; init_done never falls except on reset.

Decomposition:
- Shared package holds:
  - State enum: INIT, RUN.
  - Special-register indices: DL_IDX=27, SP_IDX=28, GP_IDX=29, AP_IDX=30, RTRUE_IDX=31.
  - Preset table constants: DL_INIT=0, AP_INIT=0, RTRUE_INIT=1.
- One natural sub-module: regfile_preset_rom, a combinational idx-to-{addr,data} lookup parameterised by SP_INIT/GP_INIT.
- Arbitration and the wait counter stay in the top module.

Test Plan:
- Release reset, no requests -> rf_we high 5 cycles with (27,0), (28,48), (29,49), (30,0), (31,1); init_done=1 with the 5th write; rf_we=0 afterwards.
- wb_valid during INIT -> wb_stall=1 for all INIT cycles. First RUN cycle: wb_stall=0, then the next edge gives rf_we=1 with wb_addr/wb_data.
- RUN, wb_valid=0, io_valid=1 addr=5 data=0xDEADBEEF -> io_ready=1 same cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF.
- RUN, wb_valid held 1 continuously, io_valid=1, MAX_WAIT=4 -> I/O denied 4 cycles, io_ready=1 and wb_stall=1 on the 5th, wb resumes on the 6th, wait_cnt back to 0.
- MAX_WAIT=0, both valid -> io_ready=1 and wb_stall=1 every cycle while io_valid stays high.
- Assert reset during INIT at idx=2, release -> rf_we falls immediately; sequence restarts at (27,0) and completes all 5 writes.
